// File: rtl/meteor_hit.sv
// Falling meteorite target: spawns at an LFSR-chosen X, falls once per frame,
// reports bullet hits and landings, then explodes or idles before respawning.
module meteor_hit #(
    parameter int         METEOR_S       = 8,
    parameter int         Y_MIN          = 15,
    parameter int         Y_MAX          = 479,
    parameter int         X_MIN          = 8,
    parameter int         FALL_SPEED     = 2,
    parameter int         EXPLODE_FRAMES = 8,
    parameter int         RESPAWN_FRAMES = 30,
    parameter logic [9:0] LFSR_SEED      = 10'h1A5
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       bullet_active,
    input  logic [9:0] bullet_X,
    input  logic [9:0] bullet_Y,
    input  logic [9:0] bullet_size,
    output logic       bullet_hit,
    output logic       score_inc,
    output logic       meteor_landed,
    output logic [9:0] meteor_X,
    output logic [9:0] meteor_Y,
    output logic [9:0] meteor_size,
    output logic       meteor_active,
    output logic       meteor_exploding
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FALL    = 2'd1,
        EXPLODE = 2'd2
    } state_t;

    localparam logic [9:0] MS_C     = 10'(METEOR_S);
    localparam logic [9:0] YMIN_C   = 10'(Y_MIN);
    localparam logic [9:0] YMAX_C   = 10'(Y_MAX);
    localparam logic [9:0] XMIN_C   = 10'(X_MIN);
    localparam logic [9:0] SPEED_C  = 10'(FALL_SPEED);
    localparam logic [9:0] EXPL_C   = 10'(EXPLODE_FRAMES - 1);
    localparam logic [9:0] RESP_C   = 10'(RESPAWN_FRAMES - 1);
    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [9:0] SEED_C   = (LFSR_SEED == 10'd0) ? 10'd1 : LFSR_SEED;

    state_t      state_r;
    logic [9:0]  cnt_r;
    logic [9:0]  lfsr_r;
    logic [9:0]  lfsr_next_s;
    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic [10:0] lim_s;
    logic        hit_s;
    logic        land_s;

    assign meteor_size = MS_C;
    assign lfsr_next_s = {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};

    // Overlap and landing tests, larger-minus-smaller so nothing wraps.
    always_comb begin
        dx_s   = 11'd0;
        dy_s   = 11'd0;
        if (bullet_X >= meteor_X) begin
            dx_s = {1'b0, bullet_X} - {1'b0, meteor_X};
        end else begin
            dx_s = {1'b0, meteor_X} - {1'b0, bullet_X};
        end
        if (bullet_Y >= meteor_Y) begin
            dy_s = {1'b0, bullet_Y} - {1'b0, meteor_Y};
        end else begin
            dy_s = {1'b0, meteor_Y} - {1'b0, bullet_Y};
        end
        lim_s  = {1'b0, bullet_size} + {1'b0, MS_C};
        hit_s  = (state_r == FALL) && bullet_active && (dx_s <= lim_s) && (dy_s <= lim_s);
        land_s = ({1'b0, meteor_Y} + {1'b0, MS_C} + {1'b0, SPEED_C}) >= {1'b0, YMAX_C};
    end

    // Meteorite state machine with registered position, flags and pulses.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r          <= IDLE;
            cnt_r            <= RESP_C;
            lfsr_r           <= SEED_C;
            meteor_X         <= 10'd0;
            meteor_Y         <= 10'd0;
            meteor_active    <= 1'b0;
            meteor_exploding <= 1'b0;
            bullet_hit       <= 1'b0;
            score_inc        <= 1'b0;
            meteor_landed    <= 1'b0;
        end else begin
            lfsr_r        <= lfsr_next_s;
            bullet_hit    <= 1'b0;
            score_inc     <= 1'b0;
            meteor_landed <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cnt_r == 10'd0) begin
                        state_r       <= FALL;
                        meteor_X      <= XMIN_C + {1'b0, lfsr_r[8:0]};
                        meteor_Y      <= YMIN_C + MS_C;
                        meteor_active <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 10'd1;
                    end
                end
                FALL: begin
                    // A hit takes priority over landing in the same frame.
                    if (hit_s) begin
                        state_r          <= EXPLODE;
                        cnt_r            <= EXPL_C;
                        bullet_hit       <= 1'b1;
                        score_inc        <= 1'b1;
                        meteor_active    <= 1'b0;
                        meteor_exploding <= 1'b1;
                    end else if (land_s) begin
                        state_r       <= IDLE;
                        cnt_r         <= RESP_C;
                        meteor_landed <= 1'b1;
                        meteor_active <= 1'b0;
                    end else begin
                        meteor_Y <= meteor_Y + SPEED_C;
                    end
                end
                EXPLODE: begin
                    if (cnt_r == 10'd0) begin
                        state_r          <= IDLE;
                        cnt_r            <= RESP_C;
                        meteor_exploding <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 10'd1;
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    cnt_r            <= RESP_C;
                    meteor_active    <= 1'b0;
                    meteor_exploding <= 1'b0;
                end
            endcase
        end
    end

endmodule
